// File: rtl/neuron_mac.sv
// -----------------------------------------------------------------------------
// neuron_mac
//
// Multiply-accumulate front end of one neuron. It holds the neuron's weight
// memory and takes a stream of signed fixed-point samples. Each sample is
// multiplied by the weight selected by the running input counter. The products
// are accumulated with saturation. After the last input of a set, the
// accumulator plus bias is emitted as a 2*dataWidth signed sum together with a
// one-cycle valid pulse.
//
// Build option:
//   NEURON_BIAS_EN : when defined, the bias register is built and
//                    sum = sat(acc + bias). When undefined, biasValid/biasIn
//                    are ignored and sum = acc. Latency is the same either way.
//
// Ports:
//   clk           in   clock, all logic on the rising edge
//   rst           in   synchronous active-high reset
//   weightValid   in   weight memory write strobe
//   weightAddr    in   weight write address [addressWidth]
//   weightIn      in   signed weight to write [dataWidth]
//   biasValid     in   bias register load strobe
//   biasIn        in   signed bias in product format [2*dataWidth]
//   myinputValid  in   input sample valid
//   myinput       in   signed input sample [dataWidth]
//   sum           out  saturated weighted sum (+bias) [2*dataWidth]
//   sumValid      out  one-cycle pulse per completed set
//
// Pipeline (E0..E3 are consecutive rising edges for the last input of a set):
//   E0  sample + weight read + valid/last registered
//   E1  full-width signed product registered
//   E2  product accumulated with saturation
//   E3  sum = sat(acc + bias), sumValid pulses; acc restarts with the next
//       set's first product if one is already in stage 2
// -----------------------------------------------------------------------------
module neuron_mac #(
    parameter int dataWidth    = 16,
    parameter int numWeight    = 784,
    parameter int addressWidth = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       weightValid,
    input  logic [addressWidth-1:0]    weightAddr,
    input  logic [dataWidth-1:0]       weightIn,
    input  logic                       biasValid,
    input  logic [2*dataWidth-1:0]     biasIn,
    input  logic                       myinputValid,
    input  logic [dataWidth-1:0]       myinput,
    output logic [2*dataWidth-1:0]     sum,
    output logic                       sumValid
);

    localparam int PW = 2 * dataWidth;
    localparam logic [addressWidth-1:0] LAST_IDX  = addressWidth'(numWeight - 1);
    localparam logic [addressWidth:0]   NUM_W     = (addressWidth + 1)'(numWeight);
    localparam logic signed [PW-1:0]    SAT_MAX   = {1'b0, {(PW-1){1'b1}}};
    localparam logic signed [PW-1:0]    SAT_MIN   = {1'b1, {(PW-1){1'b0}}};

    // Two's-complement add that clamps on overflow. Overflow is only possible
    // when both operands share a sign and the result sign differs from it.
    function automatic logic signed [PW-1:0] sat_add(input logic signed [PW-1:0] a,
                                                     input logic signed [PW-1:0] b);
        logic signed [PW-1:0] s;
        s = a + b;
        if (!a[PW-1] && !b[PW-1] && s[PW-1]) return SAT_MAX;
        if (a[PW-1] && b[PW-1] && !s[PW-1])  return SAT_MIN;
        return s;
    endfunction

    // ------------------------------------------------------------------------
    // Weight memory and stage-1/stage-2 datapath
    // ------------------------------------------------------------------------
    logic [dataWidth-1:0]        weight_mem [numWeight];
    logic signed [dataWidth-1:0] in_q;
    logic signed [dataWidth-1:0] w_q;
    logic signed [PW-1:0]        in_ext;
    logic signed [PW-1:0]        w_ext;
    logic signed [PW-1:0]        prod_q;

    // Control state
    logic [addressWidth-1:0]     cnt_q, cnt_d;
    logic                        v1_q, last1_q;
    logic                        v2_q, last2_q;
    logic                        last3_q;
    logic signed [PW-1:0]        acc_q, acc_d;
    logic signed [PW-1:0]        sum_q, sum_d;
    logic                        sum_valid_q;
    logic signed [PW-1:0]        final_sum;

    // Sign-extend both factors so the low PW bits of the product are exact.
    assign in_ext = {{dataWidth{in_q[dataWidth-1]}}, in_q};
    assign w_ext  = {{dataWidth{w_q[dataWidth-1]}}, w_q};

    // NOTE: memory and pure datapath registers carry no reset; only the control
    // state that decides what is valid needs one.
    always_ff @(posedge clk) begin
        // Out-of-range writes are dropped instead of aliasing onto other words.
        if (weightValid && ({1'b0, weightAddr} < NUM_W)) begin
            weight_mem[weightAddr] <= weightIn;
        end
        // A read and a write of the same word on one edge returns the old data.
        w_q    <= weight_mem[cnt_q];
        in_q   <= myinput;
        prod_q <= in_ext * w_ext;
    end

`ifdef NEURON_BIAS_EN
    logic signed [PW-1:0] bias_q;

    always_ff @(posedge clk) begin
        if (biasValid) begin
            bias_q <= biasIn;
        end
    end

    assign final_sum = sat_add(acc_q, bias_q);
`else
    logic unused_bias;

    assign unused_bias = ^{biasValid, biasIn};
    assign final_sum   = acc_q;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value held and infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        sum_d = sum_q;

        if (myinputValid) begin
            cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
        end

        if (last3_q) begin
            // The set just closed. A product already in stage 2 belongs to the
            // next set, so it seeds the accumulator directly.
            sum_d = final_sum;
            acc_d = v2_q ? prod_q : '0;
        end else if (v2_q) begin
            acc_d = sat_add(acc_q, prod_q);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            v1_q        <= 1'b0;
            last1_q     <= 1'b0;
            v2_q        <= 1'b0;
            last2_q     <= 1'b0;
            last3_q     <= 1'b0;
            acc_q       <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            v1_q        <= myinputValid;
            last1_q     <= myinputValid && (cnt_q == LAST_IDX);
            v2_q        <= v1_q;
            last2_q     <= v1_q && last1_q;
            last3_q     <= v2_q && last2_q;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            sum_valid_q <= last3_q;
        end
    end

    assign sum      = sum_q;
    assign sumValid = sum_valid_q;

endmodule

// File: tb/tb_neuron_mac.sv
// -----------------------------------------------------------------------------
// Self-checking bench for neuron_mac (numWeight = 4).
// The reference model computes each set's result with 64-bit integer
// arithmetic and clamping. The expected pulse time is derived from the cycle
// in which the last input was presented.
// -----------------------------------------------------------------------------
module tb_neuron_mac;

    localparam int DW = 16;
    localparam int NW = 4;
    localparam int AW = 2;
    localparam int PW = 2 * DW;

    typedef logic [DW-1:0] vec_t [NW];

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              weightValid = 1'b0;
    logic [AW-1:0]     weightAddr = '0;
    logic [DW-1:0]     weightIn = '0;
    logic              biasValid = 1'b0;
    logic [PW-1:0]     biasIn = '0;
    logic              myinputValid = 1'b0;
    logic [DW-1:0]     myinput = '0;
    logic [PW-1:0]     sum;
    logic              sumValid;

    always #5 clk = ~clk;

    neuron_mac #(
        .dataWidth   (DW),
        .numWeight   (NW),
        .addressWidth(AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .weightValid (weightValid),
        .weightAddr  (weightAddr),
        .weightIn    (weightIn),
        .biasValid   (biasValid),
        .biasIn      (biasIn),
        .myinputValid(myinputValid),
        .myinput     (myinput),
        .sum         (sum),
        .sumValid    (sumValid)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed pulses and expected pulses
    logic [PW-1:0] got_sum_q [$];
    int            got_cyc_q [$];
    logic [PW-1:0] exp_sum_q [$];
    int            exp_cyc_q [$];

    always @(negedge clk) begin
        if (sumValid === 1'b1) begin
            got_sum_q.push_back(sum);
            got_cyc_q.push_back(cyc);
        end
    end

    int total = 0;
    int bad   = 0;

    vec_t          model_w;
    logic [PW-1:0] model_bias = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint clamp32(input longint v);
        if (v > 64'sd2147483647)  return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    // Result of one set: saturating running sum of w*x, plus optional bias.
    function automatic logic [PW-1:0] model_sum(input vec_t w, input vec_t x,
                                                input logic [PW-1:0] b);
        longint acc;
        longint p;
        acc = 0;
        for (int i = 0; i < NW; i++) begin
            p   = longint'($signed(w[i])) * longint'($signed(x[i]));
            acc = clamp32(acc + p);
        end
`ifdef NEURON_BIAS_EN
        acc = clamp32(acc + longint'($signed(b)));
`else
        if (b === 'x) acc = acc;
`endif
        return acc[PW-1:0];
    endfunction

    function automatic vec_t splat(input logic [DW-1:0] v);
        vec_t r;
        foreach (r[i]) r[i] = v;
        return r;
    endfunction

    task automatic load_weights(input vec_t w);
        for (int i = 0; i < NW; i++) begin
            weightValid = 1'b1;
            weightAddr  = AW'(i);
            weightIn    = w[i];
            @(negedge clk);
        end
        weightValid = 1'b0;
        model_w     = w;
    endtask

    task automatic load_bias(input logic [PW-1:0] b);
        biasValid = 1'b1;
        biasIn    = b;
        @(negedge clk);
        biasValid  = 1'b0;
        model_bias = b;
    endtask

    // Presents one full set. Back-to-back calls leave no idle cycle between
    // sets when max_gap is 0.
    task automatic run_set(input vec_t x, input int max_gap);
        int last_cyc;
        int g;
        last_cyc = 0;
        for (int i = 0; i < NW; i++) begin
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (g) begin
                myinputValid = 1'b0;
                @(negedge clk);
            end
            myinputValid = 1'b1;
            myinput      = x[i];
            last_cyc     = cyc;
            @(negedge clk);
        end
        myinputValid = 1'b0;
        exp_sum_q.push_back(model_sum(model_w, x, model_bias));
        // The last input is sampled on the next edge; the pulse is seen 3 edges after that.
        exp_cyc_q.push_back(last_cyc + 4);
    endtask

    task automatic verify(input string tag);
        int n;
        repeat (8) @(negedge clk);
        check({tag, ".pulses"}, 64'(got_sum_q.size()), 64'(exp_sum_q.size()));
        n = (got_sum_q.size() < exp_sum_q.size()) ? got_sum_q.size() : exp_sum_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s.sum%0d", tag, i), 64'(got_sum_q[i]), 64'(exp_sum_q[i]));
            check($sformatf("%s.cyc%0d", tag, i), 64'(got_cyc_q[i]), 64'(exp_cyc_q[i]));
        end
        if (exp_sum_q.size() > 0) begin
            check({tag, ".hold"}, 64'(sum), 64'(exp_sum_q[exp_sum_q.size()-1]));
        end
        check({tag, ".idle_valid"}, 64'(sumValid), 64'(0));
        check({tag, ".cnt_wrap"}, 64'(dut.cnt_q), 64'(0));
        got_sum_q.delete();
        got_cyc_q.delete();
        exp_sum_q.delete();
        exp_cyc_q.delete();
    endtask

    initial begin
        vec_t w;
        vec_t x1;
        vec_t x2;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset.sum", 64'(sum), 64'(0));
        check("reset.valid", 64'(sumValid), 64'(0));
        check("reset.cnt", 64'(dut.cnt_q), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Basic set: 4 x (0x1000 * 0x1000) + bias
        load_weights(splat(16'h1000));
        load_bias(32'h0080_0000);
        run_set(splat(16'h1000), 0);
        verify("basic");

        // Positive saturation
        load_weights(splat(16'h7FFF));
        load_bias(32'h0);
        run_set(splat(16'h7FFF), 0);
        verify("pos_sat");

        // Negative saturation
        load_weights(splat(16'h8000));
        run_set(splat(16'h7FFF), 0);
        verify("neg_sat");

        // Two sets back-to-back, no bubble
        load_weights(splat(16'h1000));
        load_bias(32'h0080_0000);
        run_set(splat(16'h1000), 0);
        run_set(splat(16'h2000), 0);
        verify("b2b");

        // Partial set discarded by reset
        myinputValid = 1'b1;
        myinput      = 16'h1000;
        @(negedge clk);
        @(negedge clk);
        myinputValid = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        check("midrst.sum_during", 64'(sum), 64'(0));
        check("midrst.valid_during", 64'(sumValid), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst.sum_after", 64'(sum), 64'(0));
        check("midrst.valid_after", 64'(sumValid), 64'(0));
        run_set(splat(16'h1000), 0);
        verify("midrst");

        // Random gaps between inputs give the same result as the gapless case
        run_set(splat(16'h1000), 3);
        run_set(splat(16'h1000), 3);
        run_set(splat(16'h1000), 3);
        verify("gaps");

        // Random weights, bias and inputs with random gaps
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < NW; k++) begin
                w[k]  = DW'($urandom);
                x1[k] = DW'($urandom);
                x2[k] = DW'($urandom);
            end
            load_weights(w);
            load_bias(PW'($urandom));
            run_set(x1, 3);
            run_set(x2, (it % 2 == 0) ? 0 : 3);
            verify($sformatf("rnd%0d", it));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Multiply-accumulate front end of a single neuron. Holds one neuron's weight memory, consumes a stream of signed fixed-point inputs and multiplies each by its weight. Accumulates the products with saturation and adds a bias. Emits the 2*dataWidth-bit weighted sum with a one-cycle valid pulse, directly consumable by the neuron's activation stage.

## Interface
- dataWidth, 16, bit-width of inputs, weights and bias source format
- numWeight, 784, inputs (and weights) per neuron; ≥2
- addressWidth, 10, weight address width; 2^addressWidth ≥ numWeight
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- weightValid  in  1  write strobe for weight memory
- weightAddr  in  addressWidth  weight write address
- weightIn  in  dataWidth  signed weight to write
- biasValid  in  1  load strobe for bias register
- biasIn  in  2*dataWidth  signed bias, already in product format
- myinputValid  in  1  input sample valid
- myinput  in  dataWidth  signed input sample
- sum  out  2*dataWidth  signed saturated weighted sum (+bias)
- sumValid  out  1  one-cycle pulse, sum is valid

## Operation
- Input counter cnt (0..numWeight-1) addresses weight memory; increments on each accepted myinputValid, wraps numWeight-1 → 0.
- Weight memory: numWeight × dataWidth, synchronous write, registered read at address cnt. Write and read of the same address in the same cycle returns the old data.
- Pipeline stage 1 (edge E0): myinput registered, weight read registered, valid and last flag (cnt==numWeight-1) registered.
- Stage 2 (E1): product = signed(input) × signed(weight), full 2*dataWidth signed, registered with valid/last.
- Stage 3 (E2): acc <= sat(acc + product) when product valid.
- Stage 4 (E3, after last product): sum <= sat(acc + bias); sumValid <= 1. In the same cycle, acc <= product if stage-2 valid (first product of next set), else 0.
- Saturating add: both operands ≥0 and result <0 → 0x7FFF…F; both <0 and result ≥0 → 0x800…0; otherwise wrapped result. Saturation is sticky only in the sense that later adds operate on the saturated value.
- Bias register loaded whenever biasValid is high; change affects the next emitted sum only if loaded before E3 of that set.
- Reset: cnt=0, acc=0, all stage valids=0, sum=0, sumValid=0. Weight memory and bias register are not reset. Reset mid-set discards the partial sum; no sumValid is produced for it.
- No back-pressure: inputs accepted every cycle myinputValid is high; a gap of any length between inputs is allowed.

## Timing
- Latency: last input sampled on E0 → sumValid high in the cycle following E3 (3 edges later).
- Back-to-back sets: first input of the next set may arrive the cycle after the last input of the previous set; no bubble required, no sample lost.
- sumValid high exactly one cycle per completed set; sum holds its value until the next completed set or reset.
- Weight writes concurrent with inference are legal; data integrity is the writer's responsibility.

## Configuration
- NEURON_BIAS_EN defined: bias register and biasValid/biasIn are active; sum = sat(acc + bias).
- Undefined: bias register is not built, biasValid/biasIn are ignored, sum = acc; latency unchanged (stage 4 still registers).

## Test plan
- numWeight=4, weights 0x1000 ×4, bias 0x0080_0000, inputs 0x1000 ×4 back-to-back → one sumValid, sum=0x0480_0000 (0x0400_0000 without NEURON_BIAS_EN), 3 edges after the last input.
- Weights 0x7FFF, inputs 0x7FFF ×4, bias 0 → sum=0x7FFF_FFFF (positive saturation).
- Weights 0x8000, inputs 0x7FFF ×4, bias 0 → sum=0x8000_0000 (negative saturation).
- Two sets back-to-back with no gap (set A as in the first scenario, then set B with inputs 0x2000) → two pulses 4 cycles apart, sum=0x0480_0000 then 0x0880_0000.
- Two inputs accepted, rst pulsed, then full set of 0x1000 → no pulse for the partial set; single sum=0x0480_0000; sum/sumValid read 0 during and right after reset.
- Inputs with random gaps (0–3 idle cycles) → same sum as the gapless case; cnt wraps back to 0 after each set.
